i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Round-robin arbiter and transaction sequencer that shares one I2C byte engine (the existing I2C master datapath) between NUM_REQ on-chip requesters.
- Each requester posts a single-byte write: 7-bit slave address plus 8-bit data.
- The block grants one requester at a time and drives the byte engine through the address and data phases.
- It handles slave NACK and a stalled engine (timeout), then returns a per-requester completion pulse with a status code.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT, 1024, max clk cycles allowed between byte_go and byte_done before abort.
- CNT_W, 11, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester level request.
- req_addr  in  NUM_REQ*7  slave address; requester i uses bits [7i+6:7i].
- req_data  in  NUM_REQ*8  write byte; requester i uses bits [8i+7:8i].
- gnt  out  NUM_REQ  one-hot grant, held for the whole transaction.
- done  out  NUM_REQ  one-cycle completion pulse to the granted requester.
- status  out  2  valid with done: 00 ok, 01 address NACK, 10 data NACK, 11 timeout.
- byte_go  out  1  one-cycle pulse: engine sends byte_out.
- byte_out  out  8  byte to transmit.
- byte_first  out  1  qualifies byte_go: precede the byte with a START.
- byte_last  out  1  qualifies byte_go: follow the byte with a STOP.
- byte_stop  out  1  one-cycle pulse: abort and issue a STOP now.
- byte_busy  in  1  engine busy (bus not idle).
- byte_done  in  1  one-cycle pulse: byte and ACK slot finished.
- byte_ack  in  1  ACK bit sampled with byte_done; 0 = ACK, 1 = NACK.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE; round-robin pointer is 0.
  - All outputs are 0: gnt, done, status, byte_go, byte_out, byte_first, byte_last, byte_stop.
- Reset mid-transaction aborts with no done pulse. The engine is reset by the same rst.
- All outputs are registered.
- FSM states: IDLE, ADDR, WAIT_A, DATA, WAIT_D, STOP, RESP.
- IDLE:
  - Enter ADDR only when byte_busy=0 and any req=1.
  - The winner is the first requesting index at or after ptr, wrapping modulo NUM_REQ.
  - Winner's address and data are latched, so later changes on req_addr/req_data are ignored.
  - gnt[winner] rises in the cycle after req is sampled.
- ADDR (1 cycle):
  - byte_go=1, byte_out={addr,1'b0}, byte_first=1, byte_last=0.
  - Timeout counter cleared.
  - Next state: WAIT_A.
- WAIT_A:
  - Counter increments each cycle.
  - byte_done with byte_ack=0 -> DATA.
  - byte_done with byte_ack=1 -> status=01, byte_stop pulse, -> STOP.
  - Counter reaching TIMEOUT-1 with no byte_done -> status=11, byte_stop pulse, -> STOP.
  - byte_done takes priority over timeout in the same cycle.
- DATA (1 cycle):
  - byte_go=1, byte_out=latched data, byte_first=0, byte_last=1.
  - Counter cleared.
  - Next state: WAIT_D.
- WAIT_D:
  - byte_done with ack=0 -> status=00, -> STOP.
  - byte_done with ack=1 -> status=10, -> STOP. No byte_stop: the engine issues STOP via byte_last.
  - Timeout is handled as in WAIT_A (status=11, byte_stop pulse).
- STOP:
  - Wait until byte_busy=0 -> RESP.
  - No timeout applies in this state.
- RESP (1 cycle):
  - done[winner]=1 and status is valid.
  - gnt drops at the end of this cycle.
  - ptr = winner+1 mod NUM_REQ.
  - Next state: IDLE.
- Requesters must drop req on seeing done. A req still high in the cycle after RESP is treated as a new request.
- A req deasserted mid-transaction is ignored; the transaction completes and done still pulses.
- byte_done outside WAIT_A/WAIT_D is ignored.
- byte_first/byte_last are 0 whenever byte_go=0.
- status holds its last value between transactions.
- Minimum transaction length: 1 (IDLE) + 1 (ADDR) + engine address time + 1 (DATA) + engine data time + STOP wait + 1 (RESP).

Decomposition:
- Package i2c_pkg holds:
  - FSM state enum;
  - status codes ST_OK, ST_ANACK, ST_DNACK, ST_TOUT;
  - the I2C write bit (R/W=0).
- One sub-module: rr_arbiter (combinational priority pick from req and ptr, returns one-hot plus index). It is reusable by future I2C read sequencers.

Test Plan:
- Single request, happy path:
  - Stimulus: req=0001, addr=7'h50, data=8'hA5; engine model ACKs both bytes.
  - Required: byte_out=8'hA0 with byte_first=1, then 8'hA5 with byte_last=1; done[0] pulses with status=00.
- Fairness:
  - Stimulus: req=1111 held continuously from reset.
  - Required: grants in order 0,1,2,3,0; each done is one cycle and gnt stays one-hot.
- Address NACK:
  - Stimulus: addr=7'h12; engine returns byte_ack=1 on the first byte.
  - Required: no second byte_go; byte_stop pulses once; status=01 on done.
- Data NACK:
  - Stimulus: engine ACKs the address, NACKs the data byte.
  - Required: status=10; byte_stop stays 0.
- Timeout:
  - Stimulus: TIMEOUT=16; engine never returns byte_done after the address byte_go.
  - Required: byte_stop pulses 16 cycles after byte_go; status=11 after byte_busy falls.
- Async reset mid-transaction:
  - Stimulus: rst=0 during WAIT_D.
  - Required: gnt, done and byte_go are 0 immediately, with no done pulse; the next request is granted from ptr=0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C transaction sequencers.
package i2c_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT_A,
      S_DATA,
      S_WAIT_D,
      S_STOP,
      S_RESP
   } state_t;

   localparam logic [1:0] ST_OK    = 2'b00;
   localparam logic [1:0] ST_ANACK = 2'b01;
   localparam logic [1:0] ST_DNACK = 2'b10;
   localparam logic [1:0] ST_TOUT  = 2'b11;

   localparam logic I2C_WR = 1'b0;

endpackage

// File: rtl/i2c_txn_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requesting index at or after ptr,
// wrapping modulo N. Returns one-hot, binary index and a valid flag.
module rr_arbiter
   import i2c_pkg::*;
#(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     pick_oh,
   output logic [IDX_W-1:0] pick_idx,
   output logic             pick_vld
);

   int unsigned j;

   always_comb begin
      pick_oh  = '0;
      pick_idx = '0;
      pick_vld = 1'b0;
      j        = 0;
      for (int unsigned k = 0; k < N; k++) begin
         j = (32'(ptr) + k) % N;
         if (!pick_vld && req[j]) begin
            pick_vld   = 1'b1;
            pick_oh[j] = 1'b1;
            pick_idx   = IDX_W'(j);
         end
      end
   end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter and single-byte-write sequencer sharing one I2C byte
// engine between NUM_REQ requesters; reports per-requester completion status.
module i2c_txn_arbiter
   import i2c_pkg::*;
#(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned CNT_W   = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [NUM_REQ*7-1:0] req_addr,
   input  logic [NUM_REQ*8-1:0] req_data,
   output logic [NUM_REQ-1:0]   gnt,
   output logic [NUM_REQ-1:0]   done,
   output logic [1:0]           status,
   output logic                 byte_go,
   output logic [7:0]           byte_out,
   output logic                 byte_first,
   output logic                 byte_last,
   output logic                 byte_stop,
   input  logic                 byte_busy,
   input  logic                 byte_done,
   input  logic                 byte_ack
);

   localparam int unsigned      IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   state_t             state, state_d;
   logic [CNT_W-1:0]   cnt, cnt_d, cnt_inc;
   logic [IDX_W-1:0]   ptr, ptr_d, win, win_d;
   logic [6:0]         addr_q, addr_d, pick_addr;
   logic [7:0]         data_q, data_d, pick_data;
   logic [NUM_REQ-1:0] gnt_d, done_d, pick_oh;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_vld;
   logic [1:0]         status_d;
   logic               go_d, first_d, last_d, stop_d;
   logic [7:0]         out_d;

   rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_rr (
      .req      (req),
      .ptr      (ptr),
      .pick_oh  (pick_oh),
      .pick_idx (pick_idx),
      .pick_vld (pick_vld)
   );

   always_comb begin
      pick_addr = '0;
      pick_data = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (pick_oh[i]) begin
            pick_addr = pick_addr | req_addr[i*7 +: 7];
            pick_data = pick_data | req_data[i*8 +: 8];
         end
      end
   end

   assign cnt_inc = cnt + 1'b1;

   // Outputs are computed alongside the next state so every port is a flop.
   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      ptr_d    = ptr;
      win_d    = win;
      addr_d   = addr_q;
      data_d   = data_q;
      gnt_d    = gnt;
      done_d   = '0;
      status_d = status;
      go_d     = 1'b0;
      out_d    = byte_out;
      first_d  = 1'b0;
      last_d   = 1'b0;
      stop_d   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (!byte_busy && pick_vld) begin
               state_d = S_ADDR;
               win_d   = pick_idx;
               addr_d  = pick_addr;
               data_d  = pick_data;
               gnt_d   = pick_oh;
               go_d    = 1'b1;
               out_d   = {pick_addr, I2C_WR};
               first_d = 1'b1;
            end
         end
         S_ADDR: begin
            state_d = S_WAIT_A;
            cnt_d   = '0;
         end
         S_WAIT_A: begin
            cnt_d = cnt_inc;
            if (byte_done) begin
               if (!byte_ack) begin
                  state_d = S_DATA;
                  go_d    = 1'b1;
                  out_d   = data_q;
                  last_d  = 1'b1;
               end else begin
                  state_d  = S_STOP;
                  status_d = ST_ANACK;
                  stop_d   = 1'b1;
               end
            end else if (cnt_inc == CNT_LAST) begin
               state_d  = S_STOP;
               status_d = ST_TOUT;
               stop_d   = 1'b1;
            end
         end
         S_DATA: begin
            state_d = S_WAIT_D;
            cnt_d   = '0;
         end
         S_WAIT_D: begin
            cnt_d = cnt_inc;
            if (byte_done) begin
               state_d  = S_STOP;
               status_d = byte_ack ? ST_DNACK : ST_OK;
            end else if (cnt_inc == CNT_LAST) begin
               state_d  = S_STOP;
               status_d = ST_TOUT;
               stop_d   = 1'b1;
            end
         end
         S_STOP: begin
            if (!byte_busy) begin
               state_d = S_RESP;
               done_d  = gnt;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            gnt_d   = '0;
            ptr_d   = (win == IDX_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         ptr        <= '0;
         win        <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         gnt        <= '0;
         done       <= '0;
         status     <= '0;
         byte_go    <= 1'b0;
         byte_out   <= '0;
         byte_first <= 1'b0;
         byte_last  <= 1'b0;
         byte_stop  <= 1'b0;
      end else begin
         state      <= state_d;
         cnt        <= cnt_d;
         ptr        <= ptr_d;
         win        <= win_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         gnt        <= gnt_d;
         done       <= done_d;
         status     <= status_d;
         byte_go    <= go_d;
         byte_out   <= out_d;
         byte_first <= first_d;
         byte_last  <= last_d;
         byte_stop  <= stop_d;
      end
   end

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Scoreboard bench for i2c_txn_arbiter with a behavioural byte-engine model.
module tb_i2c_txn_arbiter;

   localparam int N  = 4;
   localparam int TO = 16;

   localparam int M_OK     = 0;
   localparam int M_ANACK  = 1;
   localparam int M_DNACK  = 2;
   localparam int M_HANG_A = 3;
   localparam int M_HANG_D = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req;
   logic [N*7-1:0] req_addr;
   logic [N*8-1:0] req_data;
   logic [N-1:0]   gnt, done;
   logic [1:0]     status;
   logic           byte_go, byte_first, byte_last, byte_stop;
   logic [7:0]     byte_out;
   logic           byte_busy, byte_done, byte_ack;

   typedef struct {
      int         idx;
      logic [6:0] addr;
      logic [7:0] data;
      int         mode;
   } exp_t;

   exp_t exp_q[$];
   int   eng_mode;
   int   model_ptr;
   int   n_chk, n_pass;
   int   cyc;

   always #5 clk = ~clk;

   i2c_txn_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_addr   (req_addr),
      .req_data   (req_data),
      .gnt        (gnt),
      .done       (done),
      .status     (status),
      .byte_go    (byte_go),
      .byte_out   (byte_out),
      .byte_first (byte_first),
      .byte_last  (byte_last),
      .byte_stop  (byte_stop),
      .byte_busy  (byte_busy),
      .byte_done  (byte_done),
      .byte_ack   (byte_ack)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic int pick(input int p, input logic [N-1:0] m);
      for (int k = 0; k < N; k++)
         if (m[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   function automatic int exp_status(input int mode);
      case (mode)
         M_ANACK:            return 1;
         M_DNACK:            return 2;
         M_HANG_A, M_HANG_D: return 3;
         default:            return 0;
      endcase
   endfunction

   function automatic int exp_gos(input int mode);
      return (mode == M_ANACK || mode == M_HANG_A) ? 1 : 2;
   endfunction

   function automatic int exp_stops(input int mode);
      return (mode == M_ANACK || mode == M_HANG_A || mode == M_HANG_D) ? 1 : 0;
   endfunction

   // Byte engine: answers each byte_go after a random latency, or never in hang modes.
   initial begin
      int pend, rel;
      bit hang, cur_first, stray_ok;
      byte_busy = 1'b0; byte_done = 1'b0; byte_ack = 1'b0;
      pend = 0; rel = 0; hang = 1'b0; cur_first = 1'b0;
      forever begin
         @(negedge clk);
         stray_ok  = !byte_busy && !byte_go;
         byte_done = 1'b0;
         byte_ack  = 1'b0;
         if (rst !== 1'b1) begin
            byte_busy = 1'b0; pend = 0; rel = 0; hang = 1'b0;
         end else begin
            if (rel > 0) begin
               rel--;
               if (rel == 0) byte_busy = 1'b0;
            end
            if (byte_go) begin
               byte_busy = 1'b1;
               cur_first = byte_first;
               hang = (eng_mode == M_HANG_A && byte_first) || (eng_mode == M_HANG_D && !byte_first);
               pend = hang ? 0 : int'($urandom_range(1, 8));
            end else if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  byte_done = 1'b1;
                  byte_ack  = cur_first ? (eng_mode == M_ANACK) : (eng_mode == M_DNACK);
                  if (byte_ack || !cur_first) rel = int'($urandom_range(1, 4));
               end
            end else if (hang && byte_stop) begin
               hang = 1'b0;
               rel  = int'($urandom_range(1, 4));
            end else if (stray_ok && $urandom_range(0, 7) == 0) begin
               byte_done = 1'b1;
               byte_ack  = 1'($urandom_range(0, 1));
            end
         end
      end
   end

   // Monitor: compares DUT activity against the expectation at the queue head.
   initial begin
      int   go_cnt, stop_cnt, last_go, last_st;
      bit   prev_done;
      exp_t e;
      go_cnt = 0; stop_cnt = 0; last_go = 0; last_st = 0; prev_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst !== 1'b1) begin
            go_cnt = 0; stop_cnt = 0; prev_done = 1'b0;
            continue;
         end
         if (prev_done) begin
            check("done_pulse", 32'(done), 0);
            check("status_hold", 32'(status), last_st);
         end
         prev_done = (done != '0);
         if (!byte_go) check("qual_idle", 32'({byte_first, byte_last}), 0);
         if (byte_go || byte_stop || done != '0) begin
            check("pending_txn", 32'(exp_q.size()), 1);
            if (exp_q.size() != 0) begin
               e = exp_q[0];
               if (byte_go) begin
                  check("gnt_go", 32'(gnt), 1 << e.idx);
                  if (go_cnt == 0) begin
                     check("addr_byte", 32'(byte_out), 32'({e.addr, 1'b0}));
                     check("addr_qual", 32'({byte_first, byte_last}), 2);
                  end else begin
                     check("data_byte", 32'(byte_out), 32'(e.data));
                     check("data_qual", 32'({byte_first, byte_last}), 1);
                  end
                  go_cnt++;
                  last_go = cyc;
               end
               if (byte_stop) begin
                  stop_cnt++;
                  if (e.mode == M_HANG_A || e.mode == M_HANG_D)
                     check("tout_delay", cyc - last_go, TO);
               end
               if (done != '0) begin
                  check("done_idx", 32'(done), 1 << e.idx);
                  check("done_gnt", 32'(gnt), 1 << e.idx);
                  check("status", 32'(status), exp_status(e.mode));
                  check("go_count", go_cnt, exp_gos(e.mode));
                  check("stop_count", stop_cnt, exp_stops(e.mode));
                  last_st = exp_status(e.mode);
                  void'(exp_q.pop_front());
                  go_cnt = 0;
                  stop_cnt = 0;
               end
            end
         end
      end
   end

   task automatic push_exp(input logic [N-1:0] mask, input int mode);
      exp_t e;
      int   w;
      w      = pick(model_ptr, mask);
      e.idx  = w;
      e.addr = req_addr[w*7 +: 7];
      e.data = req_data[w*8 +: 8];
      e.mode = mode;
      exp_q.push_back(e);
      model_ptr = (w + 1) % N;
   endtask

   task automatic wait_done();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (done != '0) begin
            got = 1'b1;
            break;
         end
      end
      check("done_seen", 32'(got), 1);
   endtask

   task automatic run_txn(input logic [N-1:0] mask, input int mode, input bit hold,
                          input bit rnd, input logic [6:0] a0, input logic [7:0] d0);
      int lat;
      @(negedge clk);
      req_addr = 28'($urandom);
      req_data = $urandom;
      if (!rnd) begin
         req_addr[6:0] = a0;
         req_data[7:0] = d0;
      end
      eng_mode = mode;
      push_exp(mask, mode);
      req = mask;
      if (!hold) begin
         for (lat = 1; lat <= 20; lat++) begin
            @(negedge clk);
            if (gnt != '0) break;
         end
         check("gnt_latency", lat, 1);
         // Changing inputs after the grant must not affect the transaction.
         req_addr = 28'($urandom);
         req_data = $urandom;
         if ($urandom_range(0, 1) == 1) req = '0;
      end
      wait_done();
      if (!hold) req = '0;
   endtask

   initial begin
      bit got;
      int r, mode;
      n_chk = 0; n_pass = 0; cyc = 0;
      req = '0; req_addr = '0; req_data = '0;
      eng_mode = M_OK; model_ptr = 0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_gnt", 32'(gnt), 0);
      check("rst_done", 32'(done), 0);
      check("rst_status", 32'(status), 0);
      check("rst_ctrl", 32'({byte_go, byte_first, byte_last, byte_stop}), 0);
      check("rst_out", 32'(byte_out), 0);
      rst = 1'b1;

      for (int i = 0; i < 5; i++) run_txn(4'hF, M_OK, 1'b1, 1'b1, 7'h0, 8'h0);
      req = '0;

      run_txn(4'b0001, M_OK,     1'b0, 1'b0, 7'h50, 8'hA5);
      run_txn(4'b0001, M_ANACK,  1'b0, 1'b0, 7'h12, 8'h3C);
      run_txn(4'b0001, M_DNACK,  1'b0, 1'b0, 7'h2A, 8'h5A);
      run_txn(4'b0001, M_HANG_A, 1'b0, 1'b0, 7'h33, 8'hC3);
      run_txn(4'b0001, M_HANG_D, 1'b0, 1'b0, 7'h7F, 8'hFF);

      for (int i = 0; i < 40; i++) begin
         r = int'($urandom_range(0, 9));
         mode = (r == 5) ? M_ANACK : (r == 6) ? M_DNACK :
                (r == 7) ? M_HANG_A : (r == 8) ? M_HANG_D : M_OK;
         run_txn(4'($urandom_range(1, 15)), mode, 1'b0, 1'b1, 7'h0, 8'h0);
      end

      // Reset during the data phase: no done, and arbitration restarts at 0.
      run_txn(4'b0010, M_OK, 1'b0, 1'b1, 7'h0, 8'h0);
      @(negedge clk);
      req_addr = 28'($urandom);
      req_data = $urandom;
      eng_mode = M_OK;
      push_exp(4'hF, M_OK);
      req = 4'hF;
      got = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (byte_go && byte_last) begin
            got = 1'b1;
            break;
         end
      end
      check("data_go_seen", 32'(got), 1);
      @(negedge clk);
      #2 rst = 1'b0;
      #1 check("rst_async", 32'({gnt, done, byte_go}), 0);
      exp_q.delete();
      model_ptr = 0;
      repeat (2) @(negedge clk);
      check("rst_no_done", 32'(done), 0);
      req_addr = 28'($urandom);
      req_data = $urandom;
      push_exp(4'hF, M_OK);
      rst = 1'b1;
      wait_done();
      req = '0;
      repeat (5) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
